// File: rtl/color_classify_pkg.sv
// Shared widths, window record and channel-slice helpers for the colour window classifier.
package color_classify_pkg;

  localparam int R_W_DEF   = 5;
  localparam int G_W_DEF   = 6;
  localparam int B_W_DEF   = 5;
  localparam int PIX_W_DEF = R_W_DEF + G_W_DEF + B_W_DEF;

  typedef struct packed {
    logic                 en;
    logic [PIX_W_DEF-1:0] lo;
    logic [PIX_W_DEF-1:0] hi;
  } window_t;

  // Index width for n classes; never below 1 so a 2-class build still has a port bit.
  function automatic int cls_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  // Pixels are packed {R,G,B} with R in the most significant bits.
  function automatic int r_lsb(input int g_w, input int b_w);
    return g_w + b_w;
  endfunction

  function automatic int g_lsb(input int b_w);
    return b_w;
  endfunction

  function automatic int b_lsb();
    return 0;
  endfunction

endpackage

// File: rtl/color_window_match.sv
// One colour window: stage 1 registers per-channel range compares, stage 2 registers their AND.
module color_window_match
  import color_classify_pkg::*;
#(
  parameter int R_W = R_W_DEF,
  parameter int G_W = G_W_DEF,
  parameter int B_W = B_W_DEF,
  localparam int PIX_W = R_W + G_W + B_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pixel,
  input  logic [PIX_W-1:0] lo,
  input  logic [PIX_W-1:0] hi,
  input  logic             en,
  input  logic             qual,
  output logic             hit
);

  localparam int RL = r_lsb(G_W, B_W);
  localparam int GL = g_lsb(B_W);
  localparam int BL = b_lsb();

  logic [2:0] ok_d, ok_q;
  logic       hit_d, hit_q;

  // A window with lo > hi on any channel fails its compare and so never matches.
  always_comb begin
    ok_d[2] = (pixel[RL +: R_W] >= lo[RL +: R_W]) && (pixel[RL +: R_W] <= hi[RL +: R_W]);
    ok_d[1] = (pixel[GL +: G_W] >= lo[GL +: G_W]) && (pixel[GL +: G_W] <= hi[GL +: G_W]);
    ok_d[0] = (pixel[BL +: B_W] >= lo[BL +: B_W]) && (pixel[BL +: B_W] <= hi[BL +: B_W]);
    if (!(en && qual)) ok_d = '0;
    hit_d = &ok_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ok_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      ok_q  <= ok_d;
      hit_q <= hit_d;
    end
  end

  assign hit = hit_q;

endmodule

// File: rtl/color_window_classifier.sv
// Classifies each pixel against NUM_CLASSES programmable colour windows and keeps per-frame hit counts.
module color_window_classifier
  import color_classify_pkg::*;
#(
  parameter int NUM_CLASSES = 4,
  parameter int R_W   = R_W_DEF,
  parameter int G_W   = G_W_DEF,
  parameter int B_W   = B_W_DEF,
  parameter int X_W   = 10,
  parameter int Y_W   = 10,
  parameter int CNT_W = 19,
  localparam int PIX_W = R_W + G_W + B_W,
  localparam int CLS_W = cls_width(NUM_CLASSES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PIX_W-1:0]             pixel_data,
  input  logic                         pixel_valid,
  input  logic                         frame_valid,
  input  logic [X_W-1:0]               pixel_x,
  input  logic [Y_W-1:0]               pixel_y,
  input  logic                         cfg_we,
  input  logic [CLS_W-1:0]             cfg_class,
  input  logic [PIX_W-1:0]             cfg_lo,
  input  logic [PIX_W-1:0]             cfg_hi,
  input  logic                         cfg_en,
  output logic [NUM_CLASSES-1:0]       class_hit,
  output logic                         hit_any,
  output logic [CLS_W-1:0]             class_id,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic                         pixel_valid_out,
  output logic                         frame_valid_out,
  output logic [NUM_CLASSES*CNT_W-1:0] count_out,
  output logic                         stats_valid
);

  typedef struct packed {
    logic             en;
    logic [PIX_W-1:0] lo;
    logic [PIX_W-1:0] hi;
  } win_t;

  win_t [NUM_CLASSES-1:0] shadow_d, shadow_q, active_d, active_q;
  logic                   gap_d, gap_q, qual;
  logic                   pv_s1_d, pv_s1_q, fv_s1_d, fv_s1_q;
  logic [X_W-1:0]         x_s1_d, x_s1_q, x_d, x_q;
  logic [Y_W-1:0]         y_s1_d, y_s1_q, y_d, y_q;
  logic                   pv_out_d, pv_out_q, fv_out_d, fv_out_q;
  logic [NUM_CLASSES-1:0] class_hit_w;
  logic [NUM_CLASSES-1:0][CNT_W-1:0] acc_d, acc_q, count_d, count_q, sum;
  logic                   stats_d, stats_q, frame_end;

  // Shadow takes writes any time; active only follows shadow while no frame is running.
  // gap_q stays low after reset until an inter-frame gap, so a frame cut by reset is never counted.
  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we && (int'(cfg_class) < NUM_CLASSES)) begin
      shadow_d[cfg_class].en = cfg_en;
      shadow_d[cfg_class].lo = cfg_lo;
      shadow_d[cfg_class].hi = cfg_hi;
    end
    active_d = frame_valid ? active_q : shadow_q;
    gap_d    = gap_q | ~frame_valid;
    qual     = pixel_valid & frame_valid & gap_q;
  end

  always_comb begin
    pv_s1_d  = pixel_valid;
    fv_s1_d  = frame_valid & gap_q;
    x_s1_d   = pixel_x;
    y_s1_d   = pixel_y;
    pv_out_d = pv_s1_q;
    fv_out_d = fv_s1_q;
    x_d      = x_s1_q;
    y_d      = y_s1_q;
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_cls
    color_window_match #(
      .R_W(R_W),
      .G_W(G_W),
      .B_W(B_W)
    ) u_match (
      .clk  (clk),
      .rst  (rst),
      .pixel(pixel_data),
      .lo   (active_q[k].lo),
      .hi   (active_q[k].hi),
      .en   (active_q[k].en),
      .qual (qual),
      .hit  (class_hit_w[k])
    );
  end

  always_comb begin
    class_id = '0;
    for (int k = NUM_CLASSES - 1; k >= 0; k--) begin
      if (class_hit_w[k]) class_id = CLS_W'(k);
    end
  end

  // The last pixel of a frame is still on the outputs at frame end, so its hit is folded into count_out.
  always_comb begin
    frame_end = !fv_s1_q && fv_out_q;
    sum       = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      sum[k] = (acc_q[k] == '1) ? acc_q[k] : acc_q[k] + CNT_W'(class_hit_w[k]);
    end
    acc_d   = frame_end ? '0 : sum;
    count_d = frame_end ? sum : count_q;
    stats_d = frame_end;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      gap_q    <= 1'b0;
      pv_s1_q  <= 1'b0;
      fv_s1_q  <= 1'b0;
      x_s1_q   <= '0;
      y_s1_q   <= '0;
      pv_out_q <= 1'b0;
      fv_out_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      stats_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      gap_q    <= gap_d;
      pv_s1_q  <= pv_s1_d;
      fv_s1_q  <= fv_s1_d;
      x_s1_q   <= x_s1_d;
      y_s1_q   <= y_s1_d;
      pv_out_q <= pv_out_d;
      fv_out_q <= fv_out_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      stats_q  <= stats_d;
    end
  end

  assign class_hit       = class_hit_w;
  assign hit_any         = |class_hit_w;
  assign x               = x_q;
  assign y               = y_q;
  assign pixel_valid_out = pv_out_q;
  assign frame_valid_out = fv_out_q;
  assign count_out       = count_q;
  assign stats_valid     = stats_q;

endmodule

// File: tb/tb_color_window_classifier.sv
// Randomised bench for color_window_classifier: a frame-level reference model feeds scoreboard queues.
module tb_color_window_classifier;

  localparam int N      = 4;
  localparam int CW     = 19;
  localparam int CW_SAT = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       pixel_data = '0;
  logic              pixel_valid = 1'b0;
  logic              frame_valid = 1'b0;
  logic [9:0]        pixel_x = '0;
  logic [9:0]        pixel_y = '0;
  logic              cfg_we = 1'b0;
  logic [1:0]        cfg_class = '0;
  logic [15:0]       cfg_lo = '0;
  logic [15:0]       cfg_hi = '0;
  logic              cfg_en = 1'b0;

  logic [N-1:0]      class_hit, s_class_hit;
  logic              hit_any, s_hit_any;
  logic [1:0]        class_id, s_class_id;
  logic [9:0]        x, y, s_x, s_y;
  logic              pixel_valid_out, frame_valid_out, s_pixel_valid_out, s_frame_valid_out;
  logic [N*CW-1:0]   count_out;
  logic [N*CW_SAT-1:0] s_count_out;
  logic              stats_valid, s_stats_valid;

  color_window_classifier #(.NUM_CLASSES(N), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .frame_valid(frame_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_en(cfg_en),
    .class_hit(class_hit), .hit_any(hit_any), .class_id(class_id), .x(x), .y(y),
    .pixel_valid_out(pixel_valid_out), .frame_valid_out(frame_valid_out),
    .count_out(count_out), .stats_valid(stats_valid)
  );

  color_window_classifier #(.NUM_CLASSES(N), .CNT_W(CW_SAT)) u_sat (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .frame_valid(frame_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_en(cfg_en),
    .class_hit(s_class_hit), .hit_any(s_hit_any), .class_id(s_class_id), .x(s_x), .y(s_y),
    .pixel_valid_out(s_pixel_valid_out), .frame_valid_out(s_frame_valid_out),
    .count_out(s_count_out), .stats_valid(s_stats_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [26:0]         exp_q[$];
  logic [N*CW-1:0]     exp_cnt_q[$];
  logic [N*CW_SAT-1:0] exp_sat_q[$];

  // ---------------- reference model ----------------
  logic        m_en_sh[N], m_en[N];
  logic [15:0] m_lo_sh[N], m_hi_sh[N], m_lo[N], m_hi[N];
  logic        m_gap;
  logic        in_frame;
  int          cnt[N];

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    return {5'(r), 6'(g), 5'(b)};
  endfunction

  // channel 0 = R, 1 = G, 2 = B, from the {R,G,B} 5/6/5 packing
  function automatic int chan(input logic [15:0] p, input int c);
    int v;
    v = int'(p);
    if (c == 0) return v / 2048;
    if (c == 1) return (v / 32) % 64;
    return v % 32;
  endfunction

  function automatic logic win_match(input int k, input logic [15:0] p);
    if (!m_en[k]) return 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (chan(p, c) < chan(m_lo[k], c) || chan(p, c) > chan(m_hi[k], c)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_en_sh[k] = 1'b0; m_en[k] = 1'b0;
      m_lo_sh[k] = '0; m_hi_sh[k] = '0; m_lo[k] = '0; m_hi[k] = '0;
      cnt[k] = 0;
    end
    m_gap = 1'b0;
    in_frame = 1'b0;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_pix(input logic pv, input logic fv, input logic [15:0] p,
                         input logic [9:0] px, input logic [9:0] py);
    pixel_valid = pv; frame_valid = fv; pixel_data = p; pixel_x = px; pixel_y = py;
  endtask

  task automatic cfg_set(input int cls, input logic [15:0] lo, input logic [15:0] hi, input logic en);
    cfg_we = 1'b1; cfg_class = 2'(cls); cfg_lo = lo; cfg_hi = hi; cfg_en = en;
  endtask

  // Predicts this cycle's outputs, advances one clock, then applies the config rules.
  task automatic cycle();
    logic [N-1:0]    eh;
    int              eid;
    logic            fq;
    logic [N*CW-1:0] em;
    logic [N*CW_SAT-1:0] es;
    eh  = '0;
    eid = 0;
    fq  = frame_valid && m_gap;
    for (int k = 0; k < N; k++) eh[k] = pixel_valid && fq && win_match(k, pixel_data);
    for (int k = N - 1; k >= 0; k--) if (eh[k]) eid = k;
    if (pixel_valid) exp_q.push_back({eh, 2'(eid), |eh, pixel_x, pixel_y});
    if (fq) begin
      in_frame = 1'b1;
      for (int k = 0; k < N; k++) if (eh[k]) cnt[k]++;
    end else if (in_frame) begin
      em = '0;
      es = '0;
      for (int k = 0; k < N; k++) begin
        em[k*CW +: CW]         = CW'((cnt[k] > (1 << CW) - 1) ? (1 << CW) - 1 : cnt[k]);
        es[k*CW_SAT +: CW_SAT] = CW_SAT'((cnt[k] > (1 << CW_SAT) - 1) ? (1 << CW_SAT) - 1 : cnt[k]);
        cnt[k] = 0;
      end
      exp_cnt_q.push_back(em);
      exp_sat_q.push_back(es);
      in_frame = 1'b0;
    end
    @(posedge clk);
    if (!frame_valid) begin
      for (int k = 0; k < N; k++) begin
        m_en[k] = m_en_sh[k]; m_lo[k] = m_lo_sh[k]; m_hi[k] = m_hi_sh[k];
      end
      m_gap = 1'b1;
    end
    if (cfg_we) begin
      m_en_sh[cfg_class] = cfg_en; m_lo_sh[cfg_class] = cfg_lo; m_hi_sh[cfg_class] = cfg_hi;
    end
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_pix(1'b0, 1'b0, '0, '0, '0);
      cycle();
    end
  endtask

  task automatic rand_cfg();
    int rl, gl, bl, rh, gh, bh;
    rl = $urandom_range(0, 24); gl = $urandom_range(0, 50); bl = $urandom_range(0, 24);
    rh = $urandom_range((rl > 2) ? rl - 2 : 0, 31);
    gh = $urandom_range((gl > 2) ? gl - 2 : 0, 63);
    bh = $urandom_range((bl > 2) ? bl - 2 : 0, 31);
    cfg_set($urandom_range(0, N - 1), rgb(rl, gl, bl), rgb(rh, gh, bh), $urandom_range(0, 3) != 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_class_hit"}, 128'(class_hit), 128'(0));
    chk({tag, "_hit_any"}, 128'(hit_any), 128'(0));
    chk({tag, "_class_id"}, 128'(class_id), 128'(0));
    chk({tag, "_x"}, 128'(x), 128'(0));
    chk({tag, "_y"}, 128'(y), 128'(0));
    chk({tag, "_pixel_valid_out"}, 128'(pixel_valid_out), 128'(0));
    chk({tag, "_frame_valid_out"}, 128'(frame_valid_out), 128'(0));
    chk({tag, "_count_out"}, 128'(count_out), 128'(0));
    chk({tag, "_stats_valid"}, 128'(stats_valid), 128'(0));
    chk({tag, "_sat_count_out"}, 128'(s_count_out), 128'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [26:0] e;
    if (pixel_valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pix_unexpected: got pixel at x=%0d y=%0d required none", x, y);
      end else begin
        e = exp_q.pop_front();
        chk("pix_out", 128'({class_hit, class_id, hit_any, x, y}), 128'(e));
        chk("sat_pix_out", 128'({s_class_hit, s_class_id, s_hit_any, s_x, s_y}), 128'(e));
      end
    end else if (!rst) begin
      chk("idle_hit", 128'(class_hit), 128'(0));
    end
    if (stats_valid === 1'b1) begin
      if (exp_cnt_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL stats_unexpected: got count_out=%0h required no stats_valid", count_out);
      end else begin
        chk("count_out", 128'(count_out), 128'(exp_cnt_q.pop_front()));
      end
    end
    if (s_stats_valid === 1'b1) begin
      if (exp_sat_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sat_stats_unexpected: got count_out=%0h required no stats_valid", s_count_out);
      end else begin
        chk("sat_count_out", 128'(s_count_out), 128'(exp_sat_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    idle(2);
    cfg_set(0, rgb(20, 0, 0), rgb(31, 15, 9), 1'b1);  cycle();
    cfg_set(1, rgb(0, 60, 0), rgb(3, 63, 2), 1'b1);   cycle();
    cfg_set(2, rgb(0, 32, 0), rgb(31, 63, 31), 1'b1); cycle();
    cfg_set(3, rgb(10, 0, 0), rgb(5, 63, 31), 1'b1);  cycle();
    idle(2);

    // frame A: directed pixels, class 0 disabled mid-frame
    set_pix(1'b1, 1'b1, 16'hF800, 10'd5, 10'd7); cycle();
    set_pix(1'b1, 1'b1, 16'h07E0, 10'd6, 10'd7); cycle();
    set_pix(1'b0, 1'b1, 16'h07E0, 10'd7, 10'd7); cycle();
    set_pix(1'b1, 1'b1, 16'h0000, 10'd8, 10'd7); cycle();
    cfg_set(0, rgb(20, 0, 0), rgb(31, 15, 9), 1'b0);
    set_pix(1'b1, 1'b1, 16'hF800, 10'd9, 10'd7); cycle();
    for (int i = 0; i < 3; i++) begin
      set_pix(1'b1, 1'b1, 16'hF800, 10'(10 + i), 10'd7); cycle();
    end
    idle(2);

    // frame B: class 0 now inactive
    for (int i = 0; i < 3; i++) begin
      set_pix(1'b1, 1'b1, 16'hF800, 10'(i), 10'd1); cycle();
    end
    set_pix(1'b1, 1'b1, 16'h07E0, 10'd3, 10'd1); cycle();
    cfg_set(0, rgb(20, 0, 0), rgb(31, 15, 9), 1'b1);
    idle(3);

    // full 64x48 frame of 16'hF800 with class 0 enabled
    for (int yy = 0; yy < 48; yy++) begin
      for (int xx = 0; xx < 64; xx++) begin
        set_pix(1'b1, 1'b1, 16'hF800, 10'(xx), 10'(yy)); cycle();
      end
    end
    idle(3);

    // randomised frames with random window rewrites
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 150; i++) begin
        if ($urandom_range(0, 9) == 0) rand_cfg();
        set_pix($urandom_range(0, 3) != 0, 1'b1, 16'($urandom), 10'(i), 10'(f)); cycle();
      end
      for (int g = 0; g < $urandom_range(1, 4); g++) begin
        if ($urandom_range(0, 2) == 0) rand_cfg();
        set_pix(1'b0, 1'b0, 16'($urandom), '0, '0); cycle();
      end
    end

    // reset in the middle of a frame
    cfg_set(0, rgb(0, 0, 0), rgb(31, 63, 31), 1'b1);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      set_pix(1'b1, 1'b1, 16'hF800, 10'(i), 10'd2); cycle();
    end
    for (int i = 0; i < 2; i++) begin
      set_pix(1'b0, 1'b1, '0, '0, '0); cycle();
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    check_all_zero("mid_reset");
    for (int i = 0; i < 10; i++) begin
      set_pix(1'b1, 1'b1, 16'hF800, 10'(20 + i), 10'd2); cycle();
    end
    idle(3);
    for (int i = 0; i < 10; i++) begin
      set_pix(1'b1, 1'b1, 16'hF800, 10'(i), 10'd3); cycle();
    end
    idle(6);

    chk("pix_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("stats_queue_empty", 128'(exp_cnt_q.size()), 128'(0));
    chk("sat_queue_empty", 128'(exp_sat_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
